ofdm_tx_cfg_seq: RTL

Configuration and frame sequencer for the OFDM_TX_CR transmitter. On a frame request it writes the mode word {MOD, STD} to the transmitter's CFG port at address 0. It then streams the standard-dependent allocation vector from a local word memory to CFG address 1, opens the frame-data gate, and holds it until the transmitter's output bus cycle (CYC_O) ends. It sits between the host/MAC control logic and OFDM_TX_CR and replaces the hand-driven CFG/frame sequencing of the bench.

---
 rtl/ofdm_tx_cfg_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ofdm_tx_cfg_seq.sv
// ofdm_tx_cfg_seq
// Configuration and frame sequencer for the OFDM_TX_CR transmitter.
// On an accepted frame request it writes the mode word {MOD, STD} to CFG
// address 0. It then streams alloc_len allocation words from a local word
// memory to CFG address 1, opens the frame-data gate, and closes it when the
// transmitter bus cycle (TX_CYC_I) ends or fails to start in time.
//
// Ports
//   CLK_I, RST_I          clock (rising edge), async active-low reset
//   REQ_I, REQ_*_I        frame request and its STD / MOD / NDS fields
//   BUSY_O, DONE_O, ERR_O sequencer status; ERR_O is valid with DONE_O
//   AL_ADR_O, AL_RD_O     allocation memory read port (data 1 cycle later)
//   AL_DAT_I              allocation memory read data
//   CFG_*                 config write port to the transmitter
//   FRM_EN_O              frame-data gate
//   TX_CYC_I              bus cycle flag of the transmitter
//
// state | meaning
// IDLE  | waiting for REQ_I
// MODE  | mode word write pending on CFG address 0
// ARD   | one-cycle allocation memory read at address k
// AWR   | allocation word write pending on CFG address 1
// GATE  | gate open, waiting for TX_CYC_I to rise (with timeout)
// RUN   | gate open, waiting for TX_CYC_I to fall
// FIN   | one-cycle DONE_O / ERR_O pulse
module ofdm_tx_cfg_seq #(
  parameter int AW  = 11,
  parameter int TMO = 4096
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          REQ_I,
  input  logic [1:0]    REQ_STD_I,
  input  logic [1:0]    REQ_MOD_I,
  input  logic [3:0]    REQ_NDS_I,
  output logic          BUSY_O,
  output logic          DONE_O,
  output logic          ERR_O,
  output logic [AW-1:0] AL_ADR_O,
  output logic          AL_RD_O,
  input  logic [31:0]   AL_DAT_I,
  output logic [31:0]   CFG_DAT_O,
  output logic [1:0]    CFG_ADR_O,
  output logic          CFG_WE_O,
  output logic          CFG_STB_O,
  input  logic          CFG_ACK_I,
  output logic          FRM_EN_O,
  input  logic          TX_CYC_I
);

  localparam int TW = $clog2(TMO);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MODE = 3'd1,
    ARD  = 3'd2,
    AWR  = 3'd3,
    GATE = 3'd4,
    RUN  = 3'd5,
    FIN  = 3'd6
  } state_t;

  state_t        state_q;
  logic [1:0]    std_q;
  logic [1:0]    mod_q;
  logic [3:0]    nds_q;
  logic [AW-1:0] k_q;
  logic          err_q;
  logic [TW-1:0] tmr_q;
  logic          stb_q;
  logic [1:0]    adr_q;
  logic [31:0]   dat_q;
  logic          cap_q;
  logic          rd_q;
  logic          frm_q;
  logic          done_q;
  logic          erro_q;

  logic [AW-1:0] nds_w;
  logic [AW-1:0] len_w;
  logic [AW-1:0] k_inc;

  always_comb begin
    nds_w = AW'(nds_q);
    case (std_q)
      2'd0:    len_w = nds_w << 2;
      2'd1:    len_w = nds_w << 4;
      2'd2:    len_w = nds_w << 7;
      default: len_w = '0;
    endcase
  end

  assign k_inc = k_q + AW'(1);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      std_q   <= '0;
      mod_q   <= '0;
      nds_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cap_q   <= 1'b0;
      rd_q    <= 1'b0;
      frm_q   <= 1'b0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      erro_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_I) begin
            std_q   <= REQ_STD_I;
            mod_q   <= REQ_MOD_I;
            nds_q   <= REQ_NDS_I;
            k_q     <= '0;
            err_q   <= 1'b0;
            stb_q   <= 1'b1;
            adr_q   <= 2'd0;
            dat_q   <= {28'd0, REQ_MOD_I, REQ_STD_I};
            state_q <= MODE;
          end
        end
        MODE: begin
          if (CFG_ACK_I) begin
            stb_q <= 1'b0;
            if (len_w != '0) begin
              rd_q    <= 1'b1;
              state_q <= ARD;
            end else begin
              frm_q   <= 1'b1;
              tmr_q   <= TW'(TMO - 1);
              state_q <= GATE;
            end
          end
        end
        ARD: begin
          stb_q   <= 1'b1;
          adr_q   <= 2'd1;
          cap_q   <= 1'b1;
          state_q <= AWR;
        end
        AWR: begin
          // Memory data is only valid in the first AWR cycle; hold it after.
          cap_q <= 1'b0;
          if (cap_q) begin
            dat_q <= AL_DAT_I;
          end
          if (CFG_ACK_I) begin
            stb_q <= 1'b0;
            k_q   <= k_inc;
            if (k_inc == len_w) begin
              frm_q   <= 1'b1;
              tmr_q   <= TW'(TMO - 1);
              state_q <= GATE;
            end else begin
              rd_q    <= 1'b1;
              state_q <= ARD;
            end
          end
        end
        GATE: begin
          if (TX_CYC_I) begin
            state_q <= RUN;
          end else if (tmr_q == '0) begin
            frm_q   <= 1'b0;
            done_q  <= 1'b1;
            erro_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        RUN: begin
          if (!TX_CYC_I) begin
            frm_q   <= 1'b0;
            done_q  <= 1'b1;
            erro_q  <= err_q;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY_O    = (state_q != IDLE);
  assign DONE_O    = done_q;
  assign ERR_O     = erro_q;
  assign AL_ADR_O  = k_q;
  assign AL_RD_O   = rd_q;
  // First AWR cycle forwards the memory word directly so a same-cycle ACK works.
  assign CFG_DAT_O = cap_q ? AL_DAT_I : dat_q;
  assign CFG_ADR_O = adr_q;
  assign CFG_STB_O = stb_q;
  assign CFG_WE_O  = stb_q;
  assign FRM_EN_O  = frm_q;

endmodule
